// File: rtl/xor_mix_pkg.sv
// Shared defaults and stage-1 bundle for the xor_mix_pipe block.
// Optional parity output is enabled with XOR_MIX_PARITY_EN.
package xor_mix_pkg;

  localparam int IN_W_D  = 3;
  localparam int KEY_W_D = 7;
  localparam int OUT_W_D = 20;
  localparam int CNT_W_D = 16;

  localparam logic [KEY_W_D-1:0] KEY_D  = 7'd6;
  localparam logic [KEY_W_D-1:0] MASK_D = 7'd0;

  typedef struct packed {
    logic [KEY_W_D-1:0] k;
    logic               acc;
  } s1_t;

endpackage

// File: rtl/xor_mix_core.sv
// Combinational k -> r mixing function:
// r = zext(k) + ~zext(k & MASK), computed at OUT_W bits.
module xor_mix_core
  import xor_mix_pkg::*;
#(
  parameter int                KEY_W = KEY_W_D,
  parameter int                OUT_W = OUT_W_D,
  parameter logic [KEY_W-1:0]  MASK  = MASK_D
) (
  input  logic [KEY_W-1:0] k,
  output logic [OUT_W-1:0] r
);

  logic [OUT_W-1:0] kz;
  logic [OUT_W-1:0] mz;

  assign kz = OUT_W'(k);
  assign mz = OUT_W'(k & MASK);
  // Complement taken after widening so upper bits become ones.
  assign r  = kz + ~mz;

endmodule

// File: rtl/xor_mix_pipe.sv
// Two-stage valid/ready XOR-mix pipeline with accumulator and beat counter.
// Define XOR_MIX_PARITY_EN to add the registered out_parity port.
module xor_mix_pipe
  import xor_mix_pkg::*;
#(
  parameter int                IN_W  = IN_W_D,
  parameter int                KEY_W = KEY_W_D,
  parameter int                OUT_W = OUT_W_D,
  parameter logic [KEY_W-1:0]  KEY   = KEY_D,
  parameter logic [KEY_W-1:0]  MASK  = MASK_D,
  parameter int                CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
`ifdef XOR_MIX_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] beat_cnt
);

  if (KEY_W != KEY_W_D) begin : g_key_w_chk
    $error("xor_mix_pipe: KEY_W must match s1_t key width");
  end

  s1_t              s1_q;
  s1_t              s1_d;
  logic             s1_valid;
  logic             s2_load;
  logic             in_fire;
  logic [OUT_W-1:0] r;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_base;
  logic [OUT_W-1:0] acc_sum;
  logic [OUT_W-1:0] res;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  assign s1_d.k   = KEY_W'(in_data) ^ KEY;
  assign s1_d.acc = in_acc;

  xor_mix_core #(
    .KEY_W (KEY_W),
    .OUT_W (OUT_W),
    .MASK  (MASK)
  ) u_core (
    .k (s1_q.k),
    .r (r)
  );

  // A clear in the same cycle as an accumulating load restarts from r.
  assign acc_base = acc_clr ? '0 : acc;
  assign acc_sum  = acc_base + r;
  assign res      = s1_q.acc ? acc_sum : r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
    end else begin
      if (in_fire) begin
        s1_q     <= s1_d;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid <= 1'b1;
        out_data  <= res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (s2_load && s1_q.acc) begin
        acc <= acc_sum;
      end else if (acc_clr) begin
        acc <= '0;
      end

      if (out_valid && out_ready) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

`ifdef XOR_MIX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (s2_load) begin
      out_parity <= ^res;
    end
  end
`endif

endmodule
